// File: rtl/quadrant_selector.sv
// Cursor controller for the VGA quadrant highlighter: debounced buttons move a
// quadrant cursor on frame boundaries, with a select-to-lock blinking mode.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | no highlight; first direction press wakes the cursor at TL
// ST_ACTIVE | cursor shown and movable; press-free frames time out to idle
// ST_LOCKED | confirmed quadrant, blinking; only sel releases it
module quadrant_selector #(
    parameter int TIMEOUT_FRAMES = 600,
    parameter int BLINK_FRAMES   = 15,
    parameter int CW             = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_tick,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_sel,
    output logic [2:0] cuadrante,
    output logic       locked,
    output logic       sel_pulse,
    output logic [2:0] sel_quad
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [CW-1:0] IDLE_LAST  = CW'(TIMEOUT_FRAMES - 1);
    localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);

    // Button vector order: {sel, up, down, left, right}
    logic [4:0] raw, sync1, sync2, samp, press;
    logic [3:0] dir_win;
    logic       p_sel, dir_any;

    state_t     state, state_n;
    logic [2:0] cursor, cursor_n;
    logic [2:0] sel_quad_n;
    logic [CW-1:0] idle_cnt, idle_n, blink_cnt, blink_n;
    logic       blink_vis, vis_n, pulse_n;

    assign raw = {btn_sel, btn_up, btn_down, btn_left, btn_right};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
            samp  <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (frame_tick)
                samp <= sync2;
        end
    end

    assign press = {5{frame_tick}} & sync2 & ~samp;

    // One press per frame: sel > up > down > left > right
    always_comb begin
        p_sel   = press[4];
        dir_win = 4'b0000;
        if (!press[4]) begin
            if (press[3])      dir_win = 4'b1000;
            else if (press[2]) dir_win = 4'b0100;
            else if (press[1]) dir_win = 4'b0010;
            else if (press[0]) dir_win = 4'b0001;
        end
        dir_any = |dir_win;
    end

    // Saturating moves on the 2x2 layout 1 TL, 2 TR, 3 BL, 4 BR
    function automatic logic [2:0] move(input logic [2:0] q, input logic [3:0] d);
        logic [2:0] r;
        r = q;
        unique case (d)
            4'b1000: if (q == 3'd3 || q == 3'd4) r = q - 3'd2;
            4'b0100: if (q == 3'd1 || q == 3'd2) r = q + 3'd2;
            4'b0010: if (q == 3'd2 || q == 3'd4) r = q - 3'd1;
            4'b0001: if (q == 3'd1 || q == 3'd3) r = q + 3'd1;
            default: r = q;
        endcase
        return r;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cursor    <= 3'd1;
            sel_quad  <= 3'd0;
            sel_pulse <= 1'b0;
            idle_cnt  <= '0;
            blink_cnt <= '0;
            blink_vis <= 1'b1;
        end else begin
            state     <= state_n;
            cursor    <= cursor_n;
            sel_quad  <= sel_quad_n;
            sel_pulse <= pulse_n;
            idle_cnt  <= idle_n;
            blink_cnt <= blink_n;
            blink_vis <= vis_n;
        end
    end

    always_comb begin
        state_n    = state;
        cursor_n   = cursor;
        sel_quad_n = sel_quad;
        pulse_n    = 1'b0;
        idle_n     = idle_cnt;
        blink_n    = blink_cnt;
        vis_n      = blink_vis;
        unique case (state)
            ST_IDLE: begin
                if (dir_any) begin
                    state_n  = ST_ACTIVE;
                    cursor_n = 3'd1;
                    idle_n   = '0;
                end
            end
            ST_ACTIVE: begin
                if (p_sel) begin
                    state_n    = ST_LOCKED;
                    sel_quad_n = cursor;
                    pulse_n    = 1'b1;
                    blink_n    = '0;
                    vis_n      = 1'b1;
                end else if (dir_any) begin
                    cursor_n = move(cursor, dir_win);
                    idle_n   = '0;
                end else if (frame_tick) begin
                    if (idle_cnt == IDLE_LAST) begin
                        state_n = ST_IDLE;
                        idle_n  = '0;
                    end else begin
                        idle_n = idle_cnt + CW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                if (p_sel) begin
                    state_n = ST_ACTIVE;
                    idle_n  = '0;
                end else if (frame_tick) begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_n = '0;
                        vis_n   = ~blink_vis;
                    end else begin
                        blink_n = blink_cnt + CW'(1);
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        cuadrante = 3'd0;
        locked    = 1'b0;
        unique case (state)
            ST_ACTIVE: cuadrante = cursor;
            ST_LOCKED: begin
                locked    = 1'b1;
                cuadrante = blink_vis ? cursor : 3'd0;
            end
            default: cuadrante = 3'd0;
        endcase
    end

endmodule

// File: tb/tb_quadrant_selector.sv
// Bench for quadrant_selector: a frame-level behavioural model checked every
// cycle, plus directed frames with hand-computed quadrant expectations.
module tb_quadrant_selector;

    localparam int TO = 4;
    localparam int BF = 2;

    localparam bit [4:0] S = 5'b10000;
    localparam bit [4:0] U = 5'b01000;
    localparam bit [4:0] D = 5'b00100;
    localparam bit [4:0] L = 5'b00010;
    localparam bit [4:0] R = 5'b00001;
    localparam bit [4:0] N = 5'b00000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic frame_tick = 1'b0;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
    logic [2:0] cuadrante, sel_quad;
    logic       locked, sel_pulse;

    int checks = 0;
    int errors = 0;

    quadrant_selector #(.TIMEOUT_FRAMES(TO), .BLINK_FRAMES(BF), .CW(10)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
        .btn_right(btn_right), .btn_sel(btn_sel),
        .cuadrante(cuadrante), .locked(locked), .sel_pulse(sel_pulse), .sel_quad(sel_quad)
    );

    always #5 clk = ~clk;

    // Model: mode 0 idle, 1 active, 2 locked; buttons seen with two-edge delay
    int m_mode, m_cur, m_vis, m_idle, m_blink, m_squad, m_pulse;
    bit [4:0] h1, h2, samp;

    function automatic int exp_cuad();
        if (m_mode == 0) return 0;
        if (m_mode == 1) return m_cur;
        return m_vis ? m_cur : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode = 0; m_cur = 1; m_vis = 1; m_idle = 0; m_blink = 0;
            m_squad = 0; m_pulse = 0; h1 = '0; h2 = '0; samp = '0;
        end else begin
            bit [4:0] pr;
            int w, row, col;
            pr = frame_tick ? (h2 & ~samp) : 5'b0;
            if (frame_tick) samp = h2;
            h2 = h1;
            h1 = {btn_sel, btn_up, btn_down, btn_left, btn_right};
            m_pulse = 0;
            w = -1;
            for (int i = 0; i < 5; i++) if (pr[i]) w = i;
            if (frame_tick) begin
                if (m_mode == 0) begin
                    if (w >= 0 && w < 4) begin m_mode = 1; m_cur = 1; m_idle = 0; end
                end else if (m_mode == 1) begin
                    if (w == 4) begin
                        m_mode = 2; m_squad = m_cur; m_pulse = 1; m_blink = 0; m_vis = 1;
                    end else if (w >= 0) begin
                        row = (m_cur - 1) / 2; col = (m_cur - 1) % 2;
                        if (w == 3) row = 0;
                        if (w == 2) row = 1;
                        if (w == 1) col = 0;
                        if (w == 0) col = 1;
                        m_cur = row * 2 + col + 1;
                        m_idle = 0;
                    end else begin
                        m_idle++;
                        if (m_idle == TO) begin m_mode = 0; m_idle = 0; end
                    end
                end else begin
                    if (w == 4) begin m_mode = 1; m_idle = 0; end
                    else begin
                        m_blink++;
                        if (m_blink == BF) begin m_blink = 0; m_vis = 1 - m_vis; end
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_cuadrante", int'(cuadrante), exp_cuad());
        chk("model_locked", int'(locked), (m_mode == 2) ? 1 : 0);
        chk("model_sel_pulse", int'(sel_pulse), m_pulse);
        chk("model_sel_quad", int'(sel_quad), m_squad);
    end

    task automatic set_btn(input bit [4:0] m);
        {btn_sel, btn_up, btn_down, btn_left, btn_right} = m;
    endtask

    // One frame: set button levels, let them settle, then a one-cycle tick
    task automatic frame(input bit [4:0] m);
        @(negedge clk);
        set_btn(m);
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    task automatic fq(input bit [4:0] m, input int exp, input string name);
        frame(m);
        chk(name, int'(cuadrante), exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_cuad", int'(cuadrante), 0);
        chk("reset_locked", int'(locked), 0);
        chk("reset_pulse", int'(sel_pulse), 0);
        chk("reset_squad", int'(sel_quad), 0);
        rst = 1'b1;

        // Wake, moves and saturation
        fq(R, 1, "wake_tl");
        fq(N, 1, "wake_hold");
        fq(R, 2, "right_tr");
        fq(D, 4, "down_br");
        fq(R, 4, "right_sat");

        // Priority up > left/right
        fq(L, 3, "left_bl");
        fq(U | L | R, 1, "prio_up");

        // Lock and blink
        fq(N, 1, "pre_lock_idle1");
        fq(R, 2, "pre_lock_tr");
        frame(S);
        chk("lock_cuad", int'(cuadrante), 2);
        chk("lock_pulse", int'(sel_pulse), 1);
        chk("lock_squad", int'(sel_quad), 2);
        chk("lock_locked", int'(locked), 1);
        @(negedge clk);
        chk("pulse_one_clk", int'(sel_pulse), 0);
        fq(N, 2, "blink_t1");
        fq(U, 0, "blink_t2");
        fq(N, 0, "blink_t3");
        fq(D, 2, "blink_t4");
        fq(N, 2, "blink_t5");
        chk("still_locked", int'(locked), 1);
        fq(S, 2, "unlock_cuad");
        chk("unlock_locked", int'(locked), 0);

        // Timeout, and restart of the count by a press
        fq(N, 2, "to_1");
        fq(N, 2, "to_2");
        fq(N, 2, "to_3");
        fq(N, 0, "to_4_idle");
        fq(D, 1, "rewake_tl");
        fq(N, 1, "rto_1");
        fq(N, 1, "rto_2");
        fq(R, 2, "rto_press");
        fq(N, 2, "rto_a");
        fq(N, 2, "rto_b");
        fq(N, 2, "rto_c");
        fq(N, 0, "rto_idle");

        // Held button moves once; short pulse between ticks is ignored
        fq(R, 1, "hold_wake");
        fq(N, 1, "hold_release");
        for (int i = 1; i <= 10; i++) begin
            frame(R);
            if (i == 1) chk("hold_move", int'(cuadrante), 2);
            if (i == 4) chk("hold_no_repeat", int'(cuadrante), 2);
        end
        chk("hold_end_idle", int'(cuadrante), 0);
        fq(N, 0, "pulse_pre");
        @(negedge clk); btn_right = 1'b1;
        @(negedge clk); btn_right = 1'b0;
        repeat (3) @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        chk("short_pulse_ignored", int'(cuadrante), 0);

        // Reset while locked with blink hidden
        fq(R, 1, "r6_wake");
        fq(S, 1, "r6_lock");
        fq(N, 1, "r6_b1");
        fq(N, 0, "r6_hidden");
        chk("r6_locked", int'(locked), 1);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midrst_cuad", int'(cuadrante), 0);
        chk("midrst_locked", int'(locked), 0);
        chk("midrst_pulse", int'(sel_pulse), 0);
        chk("midrst_squad", int'(sel_quad), 0);
        set_btn(D);
        @(negedge clk);
        rst = 1'b1;
        fq(D, 1, "held_through_reset");
        chk("post_rst_squad", int'(sel_quad), 0);
        fq(R, 2, "post_rst_right");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got running expected finished");
        $fatal(1);
    end

endmodule
